// File: rtl/word_block_packer_pkg.sv
//------------------------------------------------------------------
// packer_pkg : shared helpers for the word-to-block packer
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package packer_pkg;

  localparam int DEF_WSIZE = 32;
  localparam int DEF_BSIZE = 256;
  localparam int DEF_NBL   = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int WPERB = DEF_BSIZE / DEF_WSIZE;
  localparam int CW    = clog2(WPERB) + 1;
  localparam int LW    = clog2(DEF_NBL) + 1;

  // Lowest bit of word slot k inside a block for the chosen word order
  function automatic int slot_lsb(input int k, input int wperb, input int wsize,
                                  input bit lsb_first);
    return lsb_first ? k * wsize : (wperb - 1 - k) * wsize;
  endfunction

endpackage

`default_nettype wire

// File: rtl/word_block_packer_if.sv
//------------------------------------------------------------------
// word_block_packer_if : word input / block output handshake bundle
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

interface word_block_packer_if
  import packer_pkg::*;
#(
  parameter int WSIZE = 32,
  parameter int BSIZE = 256,
  parameter int NBL   = 4
);
  localparam int IF_CW = clog2(BSIZE / WSIZE) + 1;
  localparam int IF_LW = clog2(NBL) + 1;

  logic [WSIZE-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             flush;
  logic [BSIZE-1:0] block_out;
  logic [IF_CW-1:0] block_count;
  logic             block_valid;
  logic             block_ready;
  logic [IF_LW-1:0] fill_level;

  modport master (
    output word_in, word_valid, flush, block_ready,
    input  word_ready, block_out, block_count, block_valid, fill_level
  );

  modport slave (
    input  word_in, word_valid, flush, block_ready,
    output word_ready, block_out, block_count, block_valid, fill_level
  );
endinterface

`default_nettype wire

// File: rtl/word_block_packer_sync_fifo.sv
//------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO, pointers wrap mod 2*FIFOLEN
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module sync_fifo
  import packer_pkg::*;
#(
  parameter int WSIZE   = 32,
  parameter int FIFOLEN = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [WSIZE-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WSIZE-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(FIFOLEN):0]   level
);
  localparam int AW = clog2(FIFOLEN);
  localparam int PW = AW + 1;

  logic [WSIZE-1:0] mem_q [FIFOLEN];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (level == PW'(FIFOLEN));
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + PW'(wr_ok);
    rd_ptr_d = rd_ptr_q + PW'(rd_ok);
    // Head is forced to zero while empty so the output is defined after reset
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

`default_nettype wire

// File: rtl/word_block_packer.sv
//------------------------------------------------------------------
// word_block_packer : packs WSIZE words into BSIZE blocks with flush
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module word_block_packer
  import packer_pkg::*;
#(
  parameter int WSIZE     = 32,
  parameter int BSIZE     = 256,
  parameter int NBL       = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  word_block_packer_if.slave bus
);
  localparam int NWORDS = BSIZE / WSIZE;
  localparam int NCW    = clog2(NWORDS) + 1;
  localparam int NLW    = clog2(NBL) + 1;

  logic [BSIZE-1:0] asm_q, asm_d, asm_next;
  logic [NCW-1:0]   count_q, count_d, count_next;
  logic             word_ready, accept, push;
  logic             fifo_full, fifo_empty;
  logic [BSIZE+NCW-1:0] fifo_rd;
  logic [NLW-1:0]   fifo_level;

  always_comb begin
    word_ready = !fifo_full || ((count_q != NCW'(NWORDS - 1)) && !bus.flush);
    accept     = bus.word_valid && word_ready;
    asm_next   = asm_q;
    for (int k = 0; k < NWORDS; k++) begin
      if (accept && (count_q == NCW'(k)))
        asm_next[slot_lsb(k, NWORDS, WSIZE, LSB_FIRST) +: WSIZE] = bus.word_in;
    end
    count_next = count_q + NCW'(accept);
    // A flush-time push includes a word accepted on the same edge
    push = (accept && (count_q == NCW'(NWORDS - 1))) ||
           (bus.flush && (count_next != '0) && !fifo_full);
    asm_d   = push ? '0 : asm_next;
    count_d = push ? '0 : count_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      asm_q   <= '0;
      count_q <= '0;
    end else begin
      asm_q   <= asm_d;
      count_q <= count_d;
    end
  end

  sync_fifo #(
    .WSIZE   (BSIZE + NCW),
    .FIFOLEN (NBL)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({count_next, asm_next}),
    .rd_en   (bus.block_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bus.word_ready  = word_ready;
  assign bus.block_valid = !fifo_empty;
  assign bus.block_out   = fifo_rd[BSIZE-1:0];
  assign bus.block_count = fifo_rd[BSIZE+NCW-1:BSIZE];
  assign bus.fill_level  = fifo_level;
endmodule

`default_nettype wire

// File: tb/tb_word_block_packer.sv
//------------------------------------------------------------------
// tb_word_block_packer : directed bench, WSIZE=32 BSIZE=128 NBL=2
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_word_block_packer;
  logic         clock;
  logic         reset;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         flush;
  logic         block_ready;
  int           n_tests;
  int           n_fail;

  word_block_packer_if #(.WSIZE(32), .BSIZE(128), .NBL(2)) if0 ();
  word_block_packer_if #(.WSIZE(32), .BSIZE(128), .NBL(2)) if1 ();

  assign if0.word_in     = word_in;
  assign if0.word_valid  = word_valid;
  assign if0.flush       = flush;
  assign if0.block_ready = block_ready;
  assign if1.word_in     = word_in;
  assign if1.word_valid  = word_valid;
  assign if1.flush       = flush;
  assign if1.block_ready = block_ready;

  word_block_packer #(.WSIZE(32), .BSIZE(128), .NBL(2), .LSB_FIRST(1'b1)) dut0 (
    .clock (clock), .reset (reset), .bus (if0)
  );
  word_block_packer #(.WSIZE(32), .BSIZE(128), .NBL(2), .LSB_FIRST(1'b0)) dut1 (
    .clock (clock), .reset (reset), .bus (if1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      word_in    = base + 32'(i);
      word_valid = 1'b1;
      tick();
    end
    word_valid = 1'b0;
  endtask

  task automatic pop_one();
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; word_in = '0; word_valid = 1'b0; flush = 1'b0; block_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (if0.block_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if0.block_valid); end
    n_tests++; if (if0.block_out !== 128'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", if0.block_out); end
    n_tests++; if (if0.block_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", if0.block_count); end
    n_tests++; if (if0.fill_level !== 2'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", if0.fill_level); end
    n_tests++; if (if0.word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", if0.word_ready); end
  endtask

  task automatic test_basic_pack();
    for (int i = 0; i < 4; i++) begin
      word_in = 32'h11 * 32'(i + 1); word_valid = 1'b1;
      tick();
    end
    word_valid = 1'b0;
    n_tests++; if (if0.block_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", if0.block_valid); end
    n_tests++; if (if0.block_out !== 128'h00000044_00000033_00000022_00000011) begin n_fail++; $display("FAIL basic_out: got %h want 00000044000000330000002200000011", if0.block_out); end
    n_tests++; if (if0.block_count !== 3'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", if0.block_count); end
    n_tests++; if (if0.fill_level !== 2'd1) begin n_fail++; $display("FAIL basic_fill: got %0d want 1", if0.fill_level); end
  endtask

  task automatic test_reverse_order();
    n_tests++; if (if1.block_out !== 128'h00000011_00000022_00000033_00000044) begin n_fail++; $display("FAIL reverse_out: got %h want 00000011000000220000003300000044", if1.block_out); end
    n_tests++; if (if1.block_count !== 3'd4) begin n_fail++; $display("FAIL reverse_count: got %0d want 4", if1.block_count); end
    pop_one();
    n_tests++; if (if0.block_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty: got %b want 0", if0.block_valid); end
  endtask

  task automatic test_flush_partial();
    send_words(2, 32'hA);
    flush = 1'b1; tick(); flush = 1'b0;
    n_tests++; if (if0.block_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", if0.block_valid); end
    n_tests++; if (if0.block_out !== 128'h00000000_00000000_0000000B_0000000A) begin n_fail++; $display("FAIL flush_out: got %h want 0000000B0000000A", if0.block_out); end
    n_tests++; if (if0.block_count !== 3'd2) begin n_fail++; $display("FAIL flush_count: got %0d want 2", if0.block_count); end
    pop_one();
    word_in = 32'hC; word_valid = 1'b1; flush = 1'b1;
    tick();
    word_valid = 1'b0; flush = 1'b0;
    n_tests++; if (if0.block_out !== 128'hC) begin n_fail++; $display("FAIL flush_word_out: got %h want c", if0.block_out); end
    n_tests++; if (if0.block_count !== 3'd1) begin n_fail++; $display("FAIL flush_word_count: got %0d want 1", if0.block_count); end
    pop_one();
    flush = 1'b1; tick(); tick(); tick(); flush = 1'b0;
    n_tests++; if (if0.block_valid !== 1'b0) begin n_fail++; $display("FAIL idle_flush_valid: got %b want 0", if0.block_valid); end
    n_tests++; if (if0.fill_level !== 2'd0) begin n_fail++; $display("FAIL idle_flush_fill: got %0d want 0", if0.fill_level); end
  endtask

  task automatic test_backpressure();
    int          stalls;
    int          npop;
    logic        pending;
    logic [127:0] got [3];
    logic [127:0] exp [3];
    exp[0] = 128'h00000004_00000003_00000002_00000001;
    exp[1] = 128'h00000008_00000007_00000006_00000005;
    exp[2] = 128'h0000000C_0000000B_0000000A_00000009;
    stalls = 0; npop = 0;
    block_ready = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      word_in = 32'(i); word_valid = 1'b1;
      #1;
      if (if0.word_ready !== 1'b1) stalls++;
      tick();
    end
    word_in = 32'd12;
    #1;
    n_tests++; if (stalls !== 0) begin n_fail++; $display("FAIL bp_stalls: got %0d want 0", stalls); end
    n_tests++; if (if0.fill_level !== 2'd2) begin n_fail++; $display("FAIL bp_fill: got %0d want 2", if0.fill_level); end
    n_tests++; if (if0.word_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", if0.word_ready); end
    tick(); tick();
    n_tests++; if (if0.word_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %b want 0", if0.word_ready); end
    block_ready = 1'b1;
    pending = 1'b1;
    for (int c = 0; c < 20 && !(npop == 3 && !pending); c++) begin
      if (if0.block_valid && npop < 3) begin got[npop] = if0.block_out; npop++; end
      else if (if0.block_valid) npop++;
      if (word_valid && if0.word_ready) pending = 1'b0;
      tick();
      if (!pending) word_valid = 1'b0;
    end
    block_ready = 1'b0;
    n_tests++; if (npop !== 3) begin n_fail++; $display("FAIL bp_npop: got %0d want 3", npop); end
    for (int b = 0; b < 3; b++) begin
      n_tests++;
      if (b >= npop || got[b] !== exp[b]) begin
        n_fail++; $display("FAIL bp_block%0d: got %h want %h", b, got[b], exp[b]);
      end
    end
    n_tests++; if (if0.fill_level !== 2'd0) begin n_fail++; $display("FAIL bp_drain_fill: got %0d want 0", if0.fill_level); end
  endtask

  task automatic test_flush_while_full();
    block_ready = 1'b0;
    send_words(10, 32'h100);
    flush = 1'b1;
    #1;
    n_tests++; if (if0.word_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ready: got %b want 0", if0.word_ready); end
    tick(); tick();
    n_tests++; if (if0.fill_level !== 2'd2) begin n_fail++; $display("FAIL ff_nopush: got %0d want 2", if0.fill_level); end
    pop_one();
    n_tests++; if (if0.fill_level !== 2'd1) begin n_fail++; $display("FAIL ff_pop: got %0d want 1", if0.fill_level); end
    tick();
    flush = 1'b0;
    n_tests++; if (if0.fill_level !== 2'd2) begin n_fail++; $display("FAIL ff_push: got %0d want 2", if0.fill_level); end
    n_tests++; if (if0.block_out !== 128'h00000107_00000106_00000105_00000104) begin n_fail++; $display("FAIL ff_head: got %h want 00000107000001060000010500000104", if0.block_out); end
    pop_one();
    n_tests++; if (if0.block_count !== 3'd2) begin n_fail++; $display("FAIL ff_count: got %0d want 2", if0.block_count); end
    n_tests++; if (if0.block_out !== 128'h00000000_00000000_00000109_00000108) begin n_fail++; $display("FAIL ff_out: got %h want 0000010900000108", if0.block_out); end
    pop_one();
    n_tests++; if (if0.fill_level !== 2'd0) begin n_fail++; $display("FAIL ff_drain: got %0d want 0", if0.fill_level); end
  endtask

  task automatic test_mid_reset();
    block_ready = 1'b0;
    send_words(6, 32'h40);
    n_tests++; if (if0.fill_level !== 2'd1) begin n_fail++; $display("FAIL mr_pre_fill: got %0d want 1", if0.fill_level); end
    reset = 1'b1; word_in = 32'hFF; word_valid = 1'b1; block_ready = 1'b1;
    tick();
    reset = 1'b0; word_valid = 1'b0; block_ready = 1'b0;
    n_tests++; if (if0.block_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b want 0", if0.block_valid); end
    n_tests++; if (if0.block_out !== 128'h0) begin n_fail++; $display("FAIL mr_out: got %h want 0", if0.block_out); end
    n_tests++; if (if0.block_count !== 3'd0) begin n_fail++; $display("FAIL mr_count: got %0d want 0", if0.block_count); end
    n_tests++; if (if0.fill_level !== 2'd0) begin n_fail++; $display("FAIL mr_fill: got %0d want 0", if0.fill_level); end
    n_tests++; if (if0.word_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %b want 1", if0.word_ready); end
    send_words(4, 32'h51);
    n_tests++; if (if0.block_out !== 128'h00000054_00000053_00000052_00000051) begin n_fail++; $display("FAIL mr_block: got %h want 00000054000000530000005200000051", if0.block_out); end
    n_tests++; if (if0.fill_level !== 2'd1) begin n_fail++; $display("FAIL mr_block_fill: got %0d want 1", if0.fill_level); end
    pop_one();
    n_tests++; if (if0.block_valid !== 1'b0) begin n_fail++; $display("FAIL mr_end_valid: got %b want 0", if0.block_valid); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_pack();
    test_reverse_order();
    test_flush_partial();
    test_backpressure();
    test_flush_while_full();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/word_block_packer.md
# word_block_packer

Synchronous, parametrised word-to-block packer for the SoC datapath. It packs `BSIZE/WSIZE` input words into one `BSIZE` block and buffers completed blocks in an internal FIFO. Both sides use valid/ready handshakes. It adds a flush operation that emits partial blocks and a selectable word order within each block. It sits between a word-wide producer (bus or DMA) and block-oriented consumers such as cipher or hash cores.

## Interface
Parameters:
- `WSIZE`, 32, input word width in bits.
- `BSIZE`, 256, output block width in bits. `WPERB = BSIZE/WSIZE` must be a power of two and at least 2.
- `NBL`, 4, depth of the block FIFO in blocks. Must be a power of two and at least 2.
- `LSB_FIRST`, 1:
  - 1: word k of a block occupies bits `[k*WSIZE +: WSIZE]`.
  - 0: word k occupies bits `[BSIZE-(k+1)*WSIZE +: WSIZE]`.

Ports (`CW = clog2(WPERB)+1`, `LW = clog2(NBL)+1`):
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `word_in`  in  WSIZE  input word.
- `word_valid`  in  1  producer offers `word_in`.
- `word_ready`  out  1  packer accepts the word this cycle.
- `flush`  in  1  level request: close the current partial block.
- `block_out`  out  BSIZE  head-of-FIFO block.
- `block_count`  out  CW  valid words in `block_out`, range 1..WPERB.
- `block_valid`  out  1  FIFO non-empty; `block_out`/`block_count` are meaningful.
- `block_ready`  in  1  consumer takes the head block.
- `fill_level`  out  LW  number of blocks held in the FIFO, range 0..NBL.

## Operation
- A word is accepted when `word_valid && word_ready` at a clock edge. It is written into the assembly register at slot `count`, and `count` increments.
- **Push conditions.** The assembly register (data plus `count`) is pushed into the FIFO when either:
  - a word is accepted with `count==WPERB-1`, or
  - `flush==1`, (`count>0` or a word is accepted this cycle), and the FIFO is not full.
- A flush that coincides with a word acceptance includes that word in the pushed block.
- After a push, `count` returns to 0 and the assembly register clears to zero. Unfilled slots of a partial block are therefore zero.
- `word_ready = !fifo_full || (count != WPERB-1 && !flush)`. `fifo_full` is the registered value `fill_level==NBL`. `word_ready` has no combinational path from `block_ready`.
- A flush with `count==0` and no accepted word has no effect; `flush` may stay high indefinitely.
- While `flush==1` and the FIFO is full:
  - no push occurs;
  - `word_ready` is 0;
  - the flush executes on the first cycle the FIFO is not full.
- A pop occurs when `block_valid && block_ready`; the next entry appears on the following cycle.
- A push and a pop on the same edge leave `fill_level` unchanged. This is legal at any level except full, where no push is possible.
- FIFO pointers are `LW` bits wide and wrap modulo `2*NBL`:
  - empty = pointers equal;
  - full = pointers differ by `NBL`.

## Timing
- **Reset values.** While `reset` is sampled high:
  - `count=0`, assembly register = 0, pointers = 0;
  - after the edge: `block_valid=0`, `block_out=0`, `block_count=0`, `fill_level=0`, `word_ready=1`.
- Reset during operation discards the partial block and all FIFO contents. A handshake in the same cycle as reset is ignored.
- **Latency.** A block completed or flushed at edge N shows `block_valid=1` in the cycle after edge N, provided the FIFO was empty.
- **Throughput.** One word per cycle sustained while the consumer drains at least one block per WPERB cycles.
- **Full FIFO.** The consumer pop and the next completing word cannot share an edge; this costs one stall cycle.
- `block_out` and `block_count` hold stable while `block_valid && !block_ready`.

## Structure
- Shared package `packer_pkg`:
  - `clog2` function;
  - derived constants `WPERB`, `CW`, `LW`;
  - the `LSB_FIRST` slot-index helper.
- Sub-module `sync_fifo`:
  - parameters `WSIZE`, `FIFOLEN`;
  - first-word-fall-through;
  - exports `full`, `empty`, `level`;
  - instantiated once with width `BSIZE+CW`;
  - reusable by other datapath blocks.
- The top level holds the assembly register, `count`, and the push/flush control.

## Test plan
Bench configuration: `WSIZE=32`, `BSIZE=128`, `NBL=2`, unless a line says otherwise.
- **Basic pack.** Reset, then words 0x11,0x22,0x33,0x44 on consecutive cycles -> next cycle `block_valid=1`, `block_out=0x00000044_00000033_00000022_00000011`, `block_count=4`.
- **Reverse order.** Same stimulus with `LSB_FIRST=0` -> `block_out=0x00000011_00000022_00000033_00000044`.
- **Flush partial.** Words 0xA, 0xB, then `flush=1` for one cycle -> one block, `block_out=0x00000000_00000000_0000000B_0000000A`, `block_count=2`. A further flush with `count=0` -> no block.
- **Backpressure.** `block_ready=0`; stream 12 words -> `fill_level` reaches 2 and `word_ready` drops with `count=3` (word 12 held off). Raise `block_ready` -> blocks pop in order and no word is lost or duplicated.
- **Flush while full.** FIFO full, two words pending, `flush=1` held -> no push and `word_ready=0`. First pop -> partial block pushed the next edge with `block_count=2`.
- **Mid-operation reset.** Reset asserted with `fill_level=1` and `count=2` -> all outputs take their reset values. A following 4-word sequence produces exactly one clean block.
